// File: rtl/uart_rx_ext.sv
// uart_rx_ext: configurable UART receiver (5..DBIT_MAX data bits, none/even/odd
// parity, 1 or 2 stop bits) with 3-sample majority voting per bit and a
// ready/valid output carrying parity, framing, break and overrun status.
module uart_rx_ext #(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_tick,
  input  logic                rx,
  input  logic [3:0]          cfg_dbit,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop,
  output logic [DBIT_MAX-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_parity_err,
  output logic                rx_frame_err,
  output logic                rx_break,
  output logic                rx_overrun
);

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_V0  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVS / 2);
  localparam logic [SW-1:0] S_DEC = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;

  state_t              state_reg, state_next;
  logic [SW-1:0]       s_reg, s_next;
  logic [3:0]          n_reg, n_next;
  logic [3:0]          dbit_reg, dbit_next;
  logic [1:0]          par_reg, par_next;
  logic                stop_reg, stop_next;
  logic [DBIT_MAX-1:0] data_reg, data_next;
  logic                samp0_reg, samp0_next;
  logic                samp1_reg, samp1_next;
  logic                perr_reg, perr_next;
  logic                ferr_reg, ferr_next;
  logic                zero_reg, zero_next;

  logic rx_meta_reg, rxs_reg, rxs_prev_reg;
  logic fall_edge, vote, par_en, in_frame, at_dec, at_end;
  logic [3:0] dbit_clamped;
  logic [DBIT_MAX-1:0] bit_sel;

  logic                fin, fin_ferr, fin_zero;
  logic                frame_done, done_perr, done_ferr, done_brk;
  logic [DBIT_MAX-1:0] done_data;

  logic [DBIT_MAX-1:0] rx_data_reg;
  logic rx_valid_reg, rx_perr_reg, rx_ferr_reg, rx_brk_reg, rx_ovr_reg;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      rxs_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg  <= rx;
      rxs_reg      <= rx_meta_reg;
      rxs_prev_reg <= rxs_reg;
    end
  end

  assign fall_edge = rxs_prev_reg & ~rxs_reg;
  assign vote      = (samp0_reg & samp1_reg) | (samp0_reg & rxs_reg) | (samp1_reg & rxs_reg);
  assign par_en    = (par_reg == 2'b01) || (par_reg == 2'b10);
  assign in_frame  = (state_reg != IDLE) && (state_reg != BRKWAIT);
  assign at_dec    = s_tick && (s_reg == S_DEC);
  assign at_end    = s_tick && (s_reg == S_END);

  // One-hot select of the data bit currently being received
  generate
    for (genvar gi = 0; gi < DBIT_MAX; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (n_reg == 4'(gi));
    end
  endgenerate

  // Clamp the requested word length into the supported range
  always_comb begin
    dbit_clamped = cfg_dbit;
    if (cfg_dbit < 4'd5)
      dbit_clamped = 4'd5;
    else if (cfg_dbit > 4'(DBIT_MAX))
      dbit_clamped = 4'(DBIT_MAX);
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      dbit_reg  <= 4'd8;
      par_reg   <= 2'b00;
      stop_reg  <= 1'b0;
      data_reg  <= '0;
      samp0_reg <= 1'b1;
      samp1_reg <= 1'b1;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      dbit_reg  <= dbit_next;
      par_reg   <= par_next;
      stop_reg  <= stop_next;
      data_reg  <= data_next;
      samp0_reg <= samp0_next;
      samp1_reg <= samp1_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      zero_reg  <= zero_next;
    end
  end

  // Next-state logic: bit timing, voting, frame assembly and completion
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    dbit_next  = dbit_reg;
    par_next   = par_reg;
    stop_next  = stop_reg;
    data_next  = data_reg;
    samp0_next = samp0_reg;
    samp1_next = samp1_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    zero_next  = zero_reg;
    fin        = 1'b0;
    fin_ferr   = ferr_reg;
    fin_zero   = zero_reg;
    frame_done = 1'b0;
    done_data  = data_reg;
    done_perr  = perr_reg;
    done_ferr  = ferr_reg;
    done_brk   = 1'b0;

    // Tick counter and the two early vote samples are common to all bit states
    if (in_frame && s_tick) begin
      s_next = (s_reg == S_END) ? '0 : s_reg + 1'b1;
      if (s_reg == S_V0) samp0_next = rxs_reg;
      if (s_reg == S_V1) samp1_next = rxs_reg;
    end

    case (state_reg)
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
          s_next     = '0;
          n_next     = '0;
          dbit_next  = dbit_clamped;
          par_next   = cfg_parity;
          stop_next  = cfg_stop;
          data_next  = '0;
          perr_next  = 1'b0;
          ferr_next  = 1'b0;
          zero_next  = 1'b1;
        end
      end
      START: begin
        if (at_dec && vote)
          state_next = IDLE;
        else if (at_end)
          state_next = DATA;
      end
      DATA: begin
        if (at_dec) begin
          data_next = data_reg | (bit_sel & {DBIT_MAX{vote}});
          if (vote) zero_next = 1'b0;
        end
        if (at_end) begin
          if (n_reg == dbit_reg - 4'd1)
            state_next = par_en ? PARITY : STOP1;
          else
            n_next = n_reg + 4'd1;
        end
      end
      PARITY: begin
        if (at_dec) begin
          if (vote) zero_next = 1'b0;
          if (vote != ((^data_reg) ^ (par_reg == 2'b10))) perr_next = 1'b1;
        end
        if (at_end) state_next = STOP1;
      end
      STOP1: begin
        if (at_dec) begin
          if (!stop_reg) begin
            fin      = 1'b1;
            fin_ferr = ~vote;
            fin_zero = zero_reg & ~vote;
          end else begin
            ferr_next = ~vote;
            zero_next = zero_reg & ~vote;
          end
        end
        if (at_end && stop_reg) state_next = STOP2;
      end
      STOP2: begin
        if (at_dec) begin
          fin      = 1'b1;
          fin_ferr = ferr_reg | ~vote;
          fin_zero = zero_reg & ~vote;
        end
      end
      BRKWAIT: begin
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A frame whose every vote after the start bit was 0 is reported as a break
    if (fin) begin
      frame_done = 1'b1;
      if (fin_zero) begin
        done_data  = '0;
        done_perr  = 1'b0;
        done_ferr  = 1'b1;
        done_brk   = 1'b1;
        state_next = BRKWAIT;
      end else begin
        done_data  = data_reg;
        done_perr  = perr_reg;
        done_ferr  = fin_ferr;
        done_brk   = 1'b0;
        state_next = IDLE;
      end
    end
  end

  // Output holding register with ready/valid handshake and overrun tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
      rx_brk_reg   <= 1'b0;
      rx_ovr_reg   <= 1'b0;
    end else if (frame_done) begin
      if (!rx_valid_reg || rx_ready) begin
        rx_data_reg  <= done_data;
        rx_valid_reg <= 1'b1;
        rx_perr_reg  <= done_perr;
        rx_ferr_reg  <= done_ferr;
        rx_brk_reg   <= done_brk;
        rx_ovr_reg   <= 1'b0;
      end else begin
        rx_ovr_reg   <= 1'b1;
      end
    end else if (rx_valid_reg && rx_ready) begin
      rx_valid_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
      rx_brk_reg   <= 1'b0;
      rx_ovr_reg   <= 1'b0;
    end
  end

  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;
  assign rx_break      = rx_brk_reg;
  assign rx_overrun    = rx_ovr_reg;

endmodule
